psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Downstream of the PE cluster: consumes the single-pulse partial sums emitted on the cluster's wired-OR output bus, accumulates them across channel passes in a local row buffer, then drains one finished, saturated output-feature-map row through a valid/ready stream toward the ofmap writer. One instance per PE cluster. Owns no control of the cluster beyond an `o_busy` status the top-level controller observes.

## Interface
- `DATA_WIDTH`, 16: signed psum / ofmap word width (matches cluster output)
- `ACC_WIDTH`, 24: signed accumulator width, must be ≥ DATA_WIDTH
- `MAX_OFMAP_WIDTH`, 64: row buffer depth; `LOG_MOW = $clog2(MAX_OFMAP_WIDTH)` localparam
- `MAX_PASSES`, 16: max channel passes; `LOG_MP = $clog2(MAX_PASSES)` localparam
- `clk` in 1: clock; one clock, everything on rising edge
- `reset_n` in 1: reset, asynchronous, active-low
- `i_start` in 1: pulse, latches config, begins a row (IDLE only)
- `i_ofmap_width` in LOG_MOW+1: psums per row pass
- `i_num_passes` in LOG_MP+1: passes to accumulate
- `i_peout_data` in DATA_WIDTH: signed psum from cluster
- `i_peout_valid` in 1: one-cycle pulse per psum; cannot be stalled
- `o_ofmap_data` out DATA_WIDTH: saturated result
- `o_ofmap_valid` out 1: result valid
- `i_ofmap_ready` in 1: downstream accepts
- `o_busy` out 1: high outside IDLE
- `o_done` out 1: one-cycle pulse after last drain handshake
- `o_drop_err` out 1: sticky, psum arrived while not ACCUM; cleared by `i_start`

## Operation
- States: IDLE → ACCUM on `i_start`; ACCUM → DRAIN after psum index W-1 of pass P-1; DRAIN → IDLE after handshake of entry W-1.
- Config latched at `i_start`; value 0 in either field is clamped to 1; values above maximum clamped to maximum.
- ACCUM: write pointer `wr_idx` (0..W-1) and pass counter `pass`. Each valid pulse: pass 0 writes sign-extended data to `buf[wr_idx]`; later passes write `buf[wr_idx] + sext(data)`, wrapping modulo 2^ACC_WIDTH. `wr_idx` wraps to 0 and `pass` increments at W-1.
- DRAIN: read pointer 0..W-1; output = `buf[rd_idx]` saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Pointer advances only on `o_ofmap_valid && i_ofmap_ready`.
- `i_peout_valid` in IDLE or DRAIN: data discarded, `o_drop_err` set. `i_start` outside IDLE: ignored. `i_start` and `i_peout_valid` same cycle in IDLE: start taken, psum dropped, error set.
- Assertion of `reset_n` low mid-operation: immediately to IDLE, counters 0, buffer contents undefined (not reset).

## Timing
- Reset values: `o_ofmap_valid`=0, `o_busy`=0, `o_done`=0, `o_drop_err`=0, `o_ofmap_data`=0.
- `o_busy` rises the cycle after `i_start`.
- Accumulation: 1-cycle read-modify-write; back-to-back pulses every cycle supported.
- Last ACCUM pulse at cycle t → `o_ofmap_valid` high at t+2 (one DRAIN prefetch cycle), data registered.
- Valid/ready: valid never drops without handshake; data stable while valid && !ready; full throughput one word/cycle with ready high.
- Last handshake at cycle t → `o_done` high at t+1, `o_busy` low at t+1, `o_ofmap_valid` low at t+1.

## Configuration
- `PSUM_RELU_EN`: defined → negative accumulated values output as 0 before saturation (ReLU fused). Undefined → signed saturated output only; no ReLU logic synthesized.

## Structure
- Shared package `slac_pkg`: `psum_state_e` enum (IDLE, ACCUM, DRAIN), default `ACC_WIDTH`, saturation helper width constants.
- One sub-module: `psum_sat` (combinational ACC_WIDTH→DATA_WIDTH saturation, ReLU under macro).
- Buffer as register array; no SRAM macro.

## Test plan
- W=4, P=1, psums 1,2,3,4 back-to-back, ready high → outputs 1,2,3,4, `o_done` one pulse, `o_drop_err`=0.
- W=3, P=3, each pass psums 100,-5,7 → outputs 300,-15,21.
- W=1, P=4, psum 0x7FFF each pass → output saturated 0x7FFF; psum 0x8000 ×4 → 0x8000 (0 with `PSUM_RELU_EN`).
- W=4, P=1, ready toggling 1-0-0-1 → data held stable while stalled, exactly 4 handshakes in order.
- Psum pulse in IDLE then during DRAIN → `o_drop_err` set and sticky, results unchanged; next `i_start` clears it.
- `reset_n` low mid-DRAIN (after 2 of 4 words) → next cycle `o_ofmap_valid`=0, `o_busy`=0; fresh W=2, P=1 row then completes correctly.

Source files
------------

// File: rtl/slac_pkg.sv
// Shared types and width defaults for the PE-cluster slice: state encoding for
// the psum accumulator and the helper used to size its saturation check.
package slac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } psum_state_e;

    localparam int PSUM_DATA_WIDTH = 16;
    localparam int PSUM_ACC_WIDTH  = 24;

    // Bits from the output sign bit up to the accumulator MSB; all must agree to be in range.
    function automatic int sat_hi_bits(input int acc_w, input int data_w);
        return acc_w - data_w + 1;
    endfunction

endpackage

// File: rtl/psum_sat.sv
// Combinational ACC_WIDTH -> DATA_WIDTH signed saturation of an accumulated psum.
// Optional fused ReLU when PSUM_RELU_EN is defined.
module psum_sat
    import slac_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int ACC_WIDTH  = PSUM_ACC_WIDTH,
    localparam int HI_W      = sat_hi_bits(ACC_WIDTH, DATA_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] sat
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [HI_W-1:0] hi_s;
    assign hi_s = acc[ACC_WIDTH-1:DATA_WIDTH-1];

    // Clamp to the signed output range (negatives forced to zero with ReLU).
    always_comb begin
        sat = acc[DATA_WIDTH-1:0];
`ifdef PSUM_RELU_EN
        if (acc[ACC_WIDTH-1]) begin
            sat = {DATA_WIDTH{1'b0}};
        end else if (|hi_s) begin
            sat = SAT_MAX;
        end else begin
            sat = acc[DATA_WIDTH-1:0];
        end
`else
        if ((&hi_s) || (~|hi_s)) begin
            sat = acc[DATA_WIDTH-1:0];
        end else if (acc[ACC_WIDTH-1]) begin
            sat = SAT_MIN;
        end else begin
            sat = SAT_MAX;
        end
`endif
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cluster psums across channel passes in a row buffer and drains one
// saturated ofmap row over valid/ready. Build option: PSUM_RELU_EN (fused ReLU).
module psum_accumulator
    import slac_pkg::*;
#(
    parameter int DATA_WIDTH      = PSUM_DATA_WIDTH,
    parameter int ACC_WIDTH       = PSUM_ACC_WIDTH,
    parameter int MAX_OFMAP_WIDTH = 64,
    parameter int MAX_PASSES      = 16,
    localparam int LOG_MOW        = $clog2(MAX_OFMAP_WIDTH),
    localparam int LOG_MP         = $clog2(MAX_PASSES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [LOG_MOW:0]      i_ofmap_width,
    input  logic [LOG_MP:0]       i_num_passes,
    input  logic [DATA_WIDTH-1:0] i_peout_data,
    input  logic                  i_peout_valid,
    output logic [DATA_WIDTH-1:0] o_ofmap_data,
    output logic                  o_ofmap_valid,
    input  logic                  i_ofmap_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_drop_err
);

    localparam logic [LOG_MOW:0]   W_ONE   = (LOG_MOW+1)'(32'd1);
    localparam logic [LOG_MOW:0]   W_MAX   = (LOG_MOW+1)'(MAX_OFMAP_WIDTH);
    localparam logic [LOG_MP:0]    P_ONE   = (LOG_MP+1)'(32'd1);
    localparam logic [LOG_MP:0]    P_MAX   = (LOG_MP+1)'(MAX_PASSES);
    localparam logic [LOG_MOW-1:0] IDX_ONE = LOG_MOW'(32'd1);
    localparam logic [LOG_MP-1:0]  PASS_ONE = LOG_MP'(32'd1);

    psum_state_e             state_r;
    logic [LOG_MOW:0]        width_r;
    logic [LOG_MP:0]         passes_r;
    logic [LOG_MOW-1:0]      wr_idx_r;
    logic [LOG_MP-1:0]       pass_r;
    logic [LOG_MOW:0]        rd_idx_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic [ACC_WIDTH-1:0]    acc_buf_r [MAX_OFMAP_WIDTH];

    logic [LOG_MOW:0]        width_cfg_s;
    logic [LOG_MP:0]         passes_cfg_s;
    logic                    wr_last_s;
    logic                    pass_last_s;
    logic [ACC_WIDTH-1:0]    psum_ext_s;
    logic [ACC_WIDTH-1:0]    rd_acc_s;
    logic [DATA_WIDTH-1:0]   rd_sat_s;

    // Clamp requested row width and pass count into 1..max.
    always_comb begin
        width_cfg_s  = i_ofmap_width;
        passes_cfg_s = i_num_passes;
        if (i_ofmap_width == {(LOG_MOW+1){1'b0}}) begin
            width_cfg_s = W_ONE;
        end else if (i_ofmap_width > W_MAX) begin
            width_cfg_s = W_MAX;
        end else begin
            width_cfg_s = i_ofmap_width;
        end
        if (i_num_passes == {(LOG_MP+1){1'b0}}) begin
            passes_cfg_s = P_ONE;
        end else if (i_num_passes > P_MAX) begin
            passes_cfg_s = P_MAX;
        end else begin
            passes_cfg_s = i_num_passes;
        end
    end

    assign wr_last_s   = ({1'b0, wr_idx_r} == (width_r - W_ONE));
    assign pass_last_s = ({1'b0, pass_r} == (passes_r - P_ONE));
    assign psum_ext_s  = ACC_WIDTH'($signed(i_peout_data));
    assign rd_acc_s    = acc_buf_r[rd_idx_r[LOG_MOW-1:0]];

    psum_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat (
        .acc (rd_acc_s),
        .sat (rd_sat_s)
    );

    // Row buffer read-modify-write; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if ((state_r == ACCUM) && i_peout_valid) begin
            if (pass_r == {LOG_MP{1'b0}}) begin
                acc_buf_r[wr_idx_r] <= psum_ext_s;
            end else begin
                acc_buf_r[wr_idx_r] <= acc_buf_r[wr_idx_r] + psum_ext_s;
            end
        end
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            width_r  <= W_ONE;
            passes_r <= P_ONE;
            wr_idx_r <= {LOG_MOW{1'b0}};
            pass_r   <= {LOG_MP{1'b0}};
            rd_idx_r <= {(LOG_MOW+1){1'b0}};
            data_r   <= {DATA_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        width_r  <= width_cfg_s;
                        passes_r <= passes_cfg_s;
                        wr_idx_r <= {LOG_MOW{1'b0}};
                        pass_r   <= {LOG_MP{1'b0}};
                        rd_idx_r <= {(LOG_MOW+1){1'b0}};
                        busy_r   <= 1'b1;
                        err_r    <= i_peout_valid;
                        state_r  <= ACCUM;
                    end else if (i_peout_valid) begin
                        err_r <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (i_peout_valid) begin
                        if (wr_last_s) begin
                            wr_idx_r <= {LOG_MOW{1'b0}};
                            if (pass_last_s) begin
                                pass_r  <= {LOG_MP{1'b0}};
                                state_r <= DRAIN;
                            end else begin
                                pass_r <= pass_r + PASS_ONE;
                            end
                        end else begin
                            wr_idx_r <= wr_idx_r + IDX_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (i_peout_valid) begin
                        err_r <= 1'b1;
                    end
                    // Output register refills whenever empty or being consumed.
                    if (!valid_r || i_ofmap_ready) begin
                        if (rd_idx_r < width_r) begin
                            data_r   <= rd_sat_s;
                            valid_r  <= 1'b1;
                            rd_idx_r <= rd_idx_r + W_ONE;
                        end else begin
                            valid_r  <= 1'b0;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            rd_idx_r <= {(LOG_MOW+1){1'b0}};
                            state_r  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ofmap_data  = data_r;
    assign o_ofmap_valid = valid_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_drop_err    = err_r;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: accumulation, saturation, stream stalls,
// drop errors and mid-drain reset.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [6:0]  i_ofmap_width = 7'd0;
    logic [4:0]  i_num_passes = 5'd0;
    logic [15:0] i_peout_data = 16'd0;
    logic        i_peout_valid = 1'b0;
    logic [15:0] o_ofmap_data;
    logic        o_ofmap_valid;
    logic        i_ofmap_ready = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic        o_drop_err;

    int tests = 0;
    int fails = 0;
    logic [15:0] sq[$];
    logic [15:0] eq[$];

    psum_accumulator dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_ofmap_width (i_ofmap_width),
        .i_num_passes  (i_num_passes),
        .i_peout_data  (i_peout_data),
        .i_peout_valid (i_peout_valid),
        .o_ofmap_data  (o_ofmap_data),
        .o_ofmap_valid (o_ofmap_valid),
        .i_ofmap_ready (i_ofmap_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_drop_err    (o_drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_row(input logic [6:0] w, input logic [4:0] p, input logic with_psum);
        i_start = 1'b1;
        i_ofmap_width = w;
        i_num_passes = p;
        i_peout_valid = with_psum;
        i_peout_data = 16'h0037;
        @(negedge clk);
        i_start = 1'b0;
        i_peout_valid = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    endtask

    task automatic send_all();
        while (sq.size() > 0) begin
            i_peout_valid = 1'b1;
            i_peout_data = sq.pop_front();
            @(negedge clk);
        end
        i_peout_valid = 1'b0;
    endtask

    task automatic collect(input logic [3:0] pat, input int n, input logic fin);
        int got = 0;
        int cyc = 0;
        int ph = 0;
        logic seen = 1'b0;
        logic stalled = 1'b0;
        logic [15:0] held = 16'd0;
        while (got < n && cyc < 200) begin
            i_ofmap_ready = seen ? pat[3 - (ph % 4)] : pat[3];
            if (stalled) begin
                chk("hold_valid", {31'd0, o_ofmap_valid}, 32'd1);
                chk("hold_data", {16'd0, o_ofmap_data}, {16'd0, held});
            end
            if (o_ofmap_valid) seen = 1'b1;
            if (o_ofmap_valid && i_ofmap_ready) begin
                chk($sformatf("data%0d", got), {16'd0, o_ofmap_data}, {16'd0, eq[got]});
                got++;
                stalled = 1'b0;
            end else if (o_ofmap_valid) begin
                held = o_ofmap_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (seen) ph++;
        end
        chk("handshakes", 32'(got), 32'(n));
        i_ofmap_ready = 1'b1;
        if (fin) begin
            chk("done_pulse", {31'd0, o_done}, 32'd1);
            chk("busy_low", {31'd0, o_busy}, 32'd0);
            chk("valid_low", {31'd0, o_ofmap_valid}, 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        end
        eq.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, o_ofmap_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_drop_err}, 32'd0);
        chk("rst_data", {16'd0, o_ofmap_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // W=4 P=1, back-to-back, with drain latency check
        start_row(7'd4, 5'd1, 1'b0);
        sq = {16'd1, 16'd2, 16'd3, 16'd4};
        eq = {16'd1, 16'd2, 16'd3, 16'd4};
        send_all();
        chk("prefetch_valid_low", {31'd0, o_ofmap_valid}, 32'd0);
        @(negedge clk);
        chk("first_valid", {31'd0, o_ofmap_valid}, 32'd1);
        chk("first_data", {16'd0, o_ofmap_data}, 32'd1);
        collect(4'b1111, 4, 1'b1);
        chk("no_err", {31'd0, o_drop_err}, 32'd0);

        // W=3 P=3
        start_row(7'd3, 5'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sq.push_back(16'd100);
            sq.push_back(16'hFFFB);
            sq.push_back(16'd7);
        end
        send_all();
        eq = {16'd300, 16'hFFF1, 16'd21};
        collect(4'b1111, 3, 1'b1);

        // W=1 P=4 positive saturation
        start_row(7'd1, 5'd4, 1'b0);
        sq = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        send_all();
        eq = {16'h7FFF};
        collect(4'b1111, 1, 1'b1);

        // W=1 P=4 negative saturation
        start_row(7'd1, 5'd4, 1'b0);
        sq = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        send_all();
`ifdef PSUM_RELU_EN
        eq = {16'h0000};
`else
        eq = {16'h8000};
`endif
        collect(4'b1111, 1, 1'b1);

        // zero config clamps to W=1 P=1
        start_row(7'd0, 5'd0, 1'b0);
        sq = {16'd5};
        send_all();
        eq = {16'd5};
        collect(4'b1111, 1, 1'b1);

        // W=4 P=1 with ready toggling 1-0-0-1
        start_row(7'd4, 5'd1, 1'b0);
        sq = {16'd10, 16'd20, 16'd30, 16'd40};
        send_all();
        eq = {16'd10, 16'd20, 16'd30, 16'd40};
        collect(4'b1001, 4, 1'b1);

        // drop error in IDLE, sticky, cleared by start
        i_peout_valid = 1'b1;
        i_peout_data = 16'h1111;
        @(negedge clk);
        i_peout_valid = 1'b0;
        chk("err_idle", {31'd0, o_drop_err}, 32'd1);
        repeat (2) @(negedge clk);
        chk("err_sticky", {31'd0, o_drop_err}, 32'd1);
        start_row(7'd2, 5'd1, 1'b0);
        chk("err_cleared", {31'd0, o_drop_err}, 32'd0);
        sq = {16'd7, 16'd8};
        send_all();
        i_peout_valid = 1'b1;
        i_peout_data = 16'h1234;
        @(negedge clk);
        i_peout_valid = 1'b0;
        chk("err_drain", {31'd0, o_drop_err}, 32'd1);
        eq = {16'd7, 16'd8};
        collect(4'b1111, 2, 1'b1);
        chk("err_after_done", {31'd0, o_drop_err}, 32'd1);

        // start with simultaneous psum: start taken, psum dropped
        start_row(7'd1, 5'd1, 1'b1);
        chk("err_start_psum", {31'd0, o_drop_err}, 32'd1);
        sq = {16'd9};
        send_all();
        eq = {16'd9};
        collect(4'b1111, 1, 1'b1);

        // reset mid-DRAIN after two words
        start_row(7'd4, 5'd1, 1'b0);
        chk("err_cleared2", {31'd0, o_drop_err}, 32'd0);
        sq = {16'd1, 16'd2, 16'd3, 16'd4};
        send_all();
        eq = {16'd1, 16'd2};
        collect(4'b1111, 2, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, o_ofmap_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        start_row(7'd2, 5'd1, 1'b0);
        sq = {16'd11, 16'd22};
        send_all();
        eq = {16'd11, 16'd22};
        collect(4'b1111, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
